// File: rtl/io_confreg_if.sv
// CPU-side register bus for the IO configuration block.
// The master drives strobe, address and write data; the slave returns read data.
interface io_confreg_if;
  logic        data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_dout;
  logic [31:0] data_din;

  modport master (
    output data_wen,
    output data_addr,
    output data_dout,
    input  data_din
  );

  modport slave (
    input  data_wen,
    input  data_addr,
    input  data_dout,
    output data_din
  );
endinterface

// File: rtl/io_confreg_gen.sv
// Memory-mapped board IO: LEDs, switches, debounced keys with press events,
// a free-running timer and a multiplexed seven-segment display.
module io_confreg_gen #(
  parameter int LED_W      = 16,
  parameter int SW_W       = 16,
  parameter int KEY_N      = 4,
  parameter int SEG_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int DEB_CYC    = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  io_confreg_if.slave           bus,
  input  logic [SW_W-1:0]       switch,
  input  logic [KEY_N-1:0]      keys,
  output logic [LED_W-1:0]      led,
  output logic [7:0]            ca,
  output logic [SEG_DIGITS-1:0] an
);

  localparam int DEB_W  = $clog2(DEB_CYC);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DIG_W  = (SEG_DIGITS > 1) ? $clog2(SEG_DIGITS) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(SEG_DIGITS - 1);

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  logic [LED_W-1:0]        r_led;
  logic [4*SEG_DIGITS-1:0] r_seg_val;
  logic [SEG_DIGITS-1:0]   r_seg_en;
  logic [SEG_DIGITS-1:0]   r_seg_dp;
  logic [31:0]             r_timer;
  logic [SW_W-1:0]         r_sw_s1, r_sw_s2;
  logic [KEY_N-1:0]        r_key_s1, r_key_s2;
  logic [KEY_N-1:0]        r_key_deb;
  logic [KEY_N-1:0]        r_key_evt;
  logic [SCAN_W-1:0]       r_scan_cnt;
  logic [DIG_W-1:0]        r_digit;
  logic [SEG_DIGITS-1:0]   r_an;
  logic [7:0]              r_ca;

  logic [2:0]  w_sel;
  logic        w_wr_led, w_wr_seg, w_wr_evt, w_wr_timer, w_wr_ctrl;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  // Only the word index is decoded; other address bits alias freely.
  assign w_sel         = bus.data_addr[4:2];
  assign w_unused_addr = &{1'b0, bus.data_addr[31:5], bus.data_addr[1:0]};
  assign w_wr_led      = bus.data_wen && (w_sel == 3'd0);
  assign w_wr_seg      = bus.data_wen && (w_sel == 3'd1);
  assign w_wr_evt      = bus.data_wen && (w_sel == 3'd4);
  assign w_wr_timer    = bus.data_wen && (w_sel == 3'd5);
  assign w_wr_ctrl     = bus.data_wen && (w_sel == 3'd6);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led     <= '0;
      r_seg_val <= '0;
      r_seg_en  <= '1;
      r_seg_dp  <= '0;
      r_timer   <= '0;
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      r_key_s1  <= '0;
      r_key_s2  <= '0;
    end else begin
      if (w_wr_led) r_led <= bus.data_dout[LED_W-1:0];
      if (w_wr_seg) r_seg_val <= bus.data_dout[4*SEG_DIGITS-1:0];
      if (w_wr_ctrl) begin
        r_seg_en <= bus.data_dout[SEG_DIGITS-1:0];
        r_seg_dp <= bus.data_dout[8 +: SEG_DIGITS];
      end
      r_timer  <= w_wr_timer ? bus.data_dout : r_timer + 32'd1;
      r_sw_s1  <= switch;
      r_sw_s2  <= r_sw_s1;
      r_key_s1 <= keys;
      r_key_s2 <= r_key_s1;
    end
  end

  // Each key accepts a new level only after DEB_CYC consecutive differing samples.
  logic [KEY_N-1:0] w_accept;
  generate
    for (genvar gi = 0; gi < KEY_N; gi++) begin : g_deb
      logic [DEB_W-1:0] r_cnt;
      logic             w_differs;
      assign w_differs    = r_key_s2[gi] != r_key_deb[gi];
      assign w_accept[gi] = w_differs && (r_cnt == DEB_LAST);
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (!w_differs || w_accept[gi]) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + DEB_W'(1);
        end
      end
    end
  endgenerate

  // A press event that lands on the same edge as its clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_deb <= '0;
      r_key_evt <= '0;
    end else begin
      r_key_deb <= r_key_deb ^ w_accept;
      r_key_evt <= (r_key_evt & ~(w_wr_evt ? bus.data_dout[KEY_N-1:0] : '0))
                 | (w_accept & r_key_s2);
    end
  end

  logic                  w_scan_wrap;
  logic [DIG_W-1:0]      w_digit_next;
  logic [3:0]            w_nib [SEG_DIGITS];
  logic [SEG_DIGITS-1:0] w_an_next;

  assign w_scan_wrap  = r_scan_cnt == SCAN_LAST;
  assign w_digit_next = !w_scan_wrap ? r_digit :
                        (r_digit == DIG_LAST) ? '0 : r_digit + DIG_W'(1);

  generate
    for (genvar gi = 0; gi < SEG_DIGITS; gi++) begin : g_digit
      assign w_nib[gi]     = r_seg_val[4*gi +: 4];
      assign w_an_next[gi] = ~(r_seg_en[gi] && (w_digit_next == DIG_W'(gi)));
    end
  endgenerate

  // an/ca are loaded from the upcoming index so they move on the same edge it does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
      r_an       <= '1;
      r_ca       <= 8'hFF;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SCAN_W'(1);
      r_digit    <= w_digit_next;
      r_an       <= w_an_next;
      r_ca       <= {~r_seg_dp[w_digit_next], hex_glyph(w_nib[w_digit_next])};
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      3'd0: w_rdata[LED_W-1:0]        = r_led;
      3'd1: w_rdata[4*SEG_DIGITS-1:0] = r_seg_val;
      3'd2: w_rdata[SW_W-1:0]         = r_sw_s2;
      3'd3: w_rdata[KEY_N-1:0]        = r_key_deb;
      3'd4: w_rdata[KEY_N-1:0]        = r_key_evt;
      3'd5: w_rdata                   = r_timer;
      3'd6: begin
        w_rdata[SEG_DIGITS-1:0]  = r_seg_en;
        w_rdata[8 +: SEG_DIGITS] = r_seg_dp;
      end
      default: w_rdata = '0;
    endcase
  end

  assign bus.data_din = w_rdata;
  assign led          = r_led;
  assign an           = r_an;
  assign ca           = r_ca;

endmodule
